match_window_counter: RTL and testbench
=======================================

Name: match_window_counter

Overview:
- Downstream consumer of the overlapping "1101" Mealy sequence detector.
- Samples the detector's per-bit match output on each qualified input bit and counts matches over fixed windows of WIN bits.
- At each window close, presents the window count through a valid/ready result port and updates a threshold alarm.
- Keeps a saturating running total of all matches, plus a sticky overrun flag for results that could not be delivered.

Parameters:
- WIN, 16: bits per window; must be >= 2.
- THRESH, 3: alarm asserts when window count >= THRESH.
- TW, 16: width of the saturating total-hit counter.
- CW (localparam) = $clog2(WIN+1): width of the window count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- clear  in  1  synchronous soft clear.
- bit_en  in  1  strobe marking a valid serial bit this cycle; same strobe that advances the detector.
- det  in  1  detector match output (Mealy, combinational); sampled only when bit_en=1.
- res_count  out  CW  window match count.
- res_valid  out  1  res_count holds an undelivered result.
- res_ready  in  1  consumer accepts the result.
- alarm  out  1  last closed window count >= THRESH.
- overrun  out  1  sticky; a window result was dropped.
- total_hits  out  TW  saturating count of all matches while running.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; bit_cnt=0, win_hits=0.
  - res_count=0, res_valid=0, alarm=0, overrun=0, total_hits=0.
- clear=1 at a clock edge:
  - Same effect as reset, applied synchronously.
  - Overrides every other input in that cycle.
- States:
  - IDLE: counters held at 0; det is ignored. Moves to RUN on the edge where en=1. The first bit counted is the one on the following edge.
  - RUN: when en=0 at an edge, go to IDLE. The partial window is discarded (bit_cnt and win_hits cleared). res_* outputs, alarm, overrun and total_hits keep their values.
- Counting in RUN:
  - hit = bit_en & det.
  - On bit_en, bit_cnt increments, and win_hits increments if hit.
  - total_hits increments on hit and saturates at 2^TW-1 (no wrap).
- Window close: RUN, bit_en=1 and bit_cnt=WIN-1.
  - final = win_hits + hit, so a hit on the last bit belongs to the closing window.
  - bit_cnt and win_hits return to 0; the next bit is index 0 of the new window.
  - alarm <= (final >= THRESH). This happens at every close, independent of the handshake.
- Result handshake:
  - Transfer occurs when res_valid & res_ready at an edge; res_valid then clears unless a new result loads on the same edge.
  - At close, if res_valid=0 or a transfer occurs on the same edge: res_count <= final, res_valid <= 1.
  - At close, if res_valid=1 and res_ready=0: the new result is dropped, overrun <= 1, and res_count is unchanged.
  - res_count is stable while res_valid=1 and res_ready=0.
  - res_valid does not depend combinationally on res_ready.
- Latency: res_valid and alarm are visible one clock after the edge that samples the closing bit.
- Arithmetic:
  - win_hits cannot exceed WIN, so CW bits suffice and no overflow check is needed.
  - Comparisons are unsigned.
- en and bit_en toggling: bit_en=0 cycles neither advance the window nor count det.
- All outputs are registered.

Decomposition:
- Shared package seq_pkg:
  - typedef of the FSM state enum (IDLE, RUN).
  - Default WIN, THRESH and TW constants, reused by the detector-chain top level and its bench.
- One sub-module is natural: sat_counter, a parameterised saturating incrementer with synchronous clear, instantiated for total_hits.

Test Plan:
- Defaults, en=1, bit_en every cycle, det pulses at window bit indices 3,6,9,12,15 (the stream 1101101101101101 through the detector) -> one cycle after the close: res_valid=1, res_count=5, alarm=1, total_hits=5.
- Next window with det at indices 2 and 15 only, res_ready=1 -> res_count=2 (last-bit hit counted), alarm=0, total_hits=7, overrun=0.
- res_ready held 0 across two window closes (3 hits, then 4 hits) -> res_count stays 3, overrun=1, alarm=1 after the second close, total_hits includes all 7.
- res_ready=1 on the same edge as a window close with res_valid=1 -> old result transferred, new count loaded, res_valid stays 1, overrun=0.
- en dropped at bit index 9 with 2 hits, then re-enabled -> partial window discarded; the next result counts only bits after re-entering RUN; total_hits retains the 2 hits.
- rst=0 asserted mid-window with res_valid=1 -> all outputs 0 immediately, without a clock edge. TW=4 build with 20 hits -> total_hits saturates at 15.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and default parameters for the "1101" detector chain.
// Used by match_window_counter, sat_counter and their benches.
package seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIN    = 16;
  localparam int DEF_THRESH = 3;
  localparam int DEF_TW     = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset and synchronous clear.
// Once it reaches all-ones it holds that value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/match_window_counter.sv
// Counts detector matches over fixed windows of WIN qualified bits and reports each
// window count over a valid/ready port, with a threshold alarm and a sticky overrun flag.
module match_window_counter
  import seq_pkg::*;
#(
  parameter  int WIN    = DEF_WIN,
  parameter  int THRESH = DEF_THRESH,
  parameter  int TW     = DEF_TW,
  localparam int CW     = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  input  logic          bit_en,
  input  logic          det,
  output logic [CW-1:0] res_count,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          alarm,
  output logic          overrun,
  output logic [TW-1:0] total_hits
);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] win_hits;
  logic [CW-1:0] final_cnt;
  logic          run_active;
  logic          hit;
  logic          close;

  // Counting only happens on edges where we are already in RUN and stay there.
  assign run_active = (state_q == RUN) && en;
  assign hit        = bit_en & det;
  assign close      = run_active && bit_en && (bit_cnt == CW'(WIN - 1));
  assign final_cnt  = win_hits + CW'(hit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      win_hits  <= '0;
      res_count <= '0;
      res_valid <= 1'b0;
      alarm     <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      bit_cnt   <= '0;
      win_hits  <= '0;
      res_count <= '0;
      res_valid <= 1'b0;
      alarm     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (run_active && bit_en) begin
        if (close) begin
          bit_cnt  <= '0;
          win_hits <= '0;
          alarm    <= (32'(final_cnt) >= $unsigned(THRESH));
          // A result that lands while the previous one is stuck is lost.
          if (!res_valid || res_ready) begin
            res_count <= final_cnt;
            res_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          bit_cnt  <= bit_cnt + CW'(1);
          win_hits <= final_cnt;
        end
      end else if (!run_active) begin
        bit_cnt  <= '0;
        win_hits <= '0;
      end
    end
  end

  sat_counter #(
    .W(TW)
  ) u_total (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (run_active & hit),
    .count (total_hits)
  );

endmodule

// File: tb/tb_match_window_counter.sv
// Directed bench for match_window_counter: windows, handshake, overrun, en drop,
// async reset and saturation of a narrow total counter.
module tb_match_window_counter;
  import seq_pkg::*;

  localparam int CW = $clog2(DEF_WIN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          clear = 1'b0;
  logic          bit_en = 1'b0;
  logic          det = 1'b0;
  logic          res_ready = 1'b0;
  logic [CW-1:0] res_count;
  logic          res_valid;
  logic          alarm;
  logic          overrun;
  logic [15:0]   total_hits;
  logic [CW-1:0] s_res_count;
  logic          s_res_valid;
  logic          s_alarm;
  logic          s_overrun;
  logic [3:0]    s_total_hits;

  int n_cmp = 0;
  int n_err = 0;

  match_window_counter dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .bit_en(bit_en), .det(det),
    .res_count(res_count), .res_valid(res_valid), .res_ready(res_ready),
    .alarm(alarm), .overrun(overrun), .total_hits(total_hits)
  );

  match_window_counter #(.TW(4)) dut_small (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .bit_en(bit_en), .det(det),
    .res_count(s_res_count), .res_valid(s_res_valid), .res_ready(res_ready),
    .alarm(s_alarm), .overrun(s_overrun), .total_hits(s_total_hits)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full window; bit i carries det=mask[i]; optional idle gaps with det=1.
  task automatic send_window(input logic [15:0] mask, input logic ready_last, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        bit_en = 1'b0;
        det    = 1'b1;
        tick();
      end
      if (i == 15) res_ready = ready_last;
      bit_en = 1'b1;
      det    = mask[i];
      tick();
    end
    bit_en = 1'b0;
    det    = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid got=%0b exp=0", res_valid); end
    n_cmp++; if (res_count !== '0) begin n_err++; $display("[TB] FAIL reset_count got=%0d exp=0", res_count); end
    n_cmp++; if ({alarm, overrun} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_flags got=%b exp=00", {alarm, overrun}); end
    n_cmp++; if (total_hits !== 16'd0) begin n_err++; $display("[TB] FAIL reset_total got=%0d exp=0", total_hits); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_window();
    en = 1'b1;
    tick();
    send_window(16'h9248, 1'b0, 1'b0);
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("[TB] FAIL basic_valid got=%0b exp=1", res_valid); end
    n_cmp++; if (res_count !== 5'd5) begin n_err++; $display("[TB] FAIL basic_count got=%0d exp=5", res_count); end
    n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("[TB] FAIL basic_alarm got=%0b exp=1", alarm); end
    n_cmp++; if (total_hits !== 16'd5) begin n_err++; $display("[TB] FAIL basic_total got=%0d exp=5", total_hits); end
  endtask

  task automatic test_last_bit_hit();
    res_ready = 1'b1;
    send_window(16'h8004, 1'b1, 1'b0);
    res_ready = 1'b0;
    n_cmp++; if (res_count !== 5'd2) begin n_err++; $display("[TB] FAIL lastbit_count got=%0d exp=2", res_count); end
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("[TB] FAIL lastbit_valid got=%0b exp=1", res_valid); end
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("[TB] FAIL lastbit_alarm got=%0b exp=0", alarm); end
    n_cmp++; if (total_hits !== 16'd7) begin n_err++; $display("[TB] FAIL lastbit_total got=%0d exp=7", total_hits); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("[TB] FAIL lastbit_overrun got=%0b exp=0", overrun); end
  endtask

  task automatic test_overrun();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("[TB] FAIL drain_valid got=%0b exp=0", res_valid); end
    send_window(16'h0111, 1'b0, 1'b0);
    n_cmp++; if (res_count !== 5'd3) begin n_err++; $display("[TB] FAIL ovr_first_count got=%0d exp=3", res_count); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("[TB] FAIL ovr_first_flag got=%0b exp=0", overrun); end
    send_window(16'h1111, 1'b0, 1'b0);
    n_cmp++; if (res_count !== 5'd3) begin n_err++; $display("[TB] FAIL ovr_held_count got=%0d exp=3", res_count); end
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("[TB] FAIL ovr_valid got=%0b exp=1", res_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("[TB] FAIL ovr_flag got=%0b exp=1", overrun); end
    n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("[TB] FAIL ovr_alarm got=%0b exp=1", alarm); end
    n_cmp++; if (total_hits !== 16'd14) begin n_err++; $display("[TB] FAIL ovr_total got=%0d exp=14", total_hits); end
  endtask

  task automatic test_back_to_back();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if ({res_valid, alarm, overrun} !== 3'b000) begin n_err++; $display("[TB] FAIL clear_flags got=%b exp=000", {res_valid, alarm, overrun}); end
    n_cmp++; if (total_hits !== 16'd0) begin n_err++; $display("[TB] FAIL clear_total got=%0d exp=0", total_hits); end
    tick();
    send_window(16'h0003, 1'b0, 1'b0);
    n_cmp++; if (res_count !== 5'd2) begin n_err++; $display("[TB] FAIL b2b_first_count got=%0d exp=2", res_count); end
    send_window(16'h000F, 1'b1, 1'b0);
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_valid got=%0b exp=1", res_valid); end
    n_cmp++; if (res_count !== 5'd4) begin n_err++; $display("[TB] FAIL b2b_count got=%0d exp=4", res_count); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_overrun got=%0b exp=0", overrun); end
    n_cmp++; if (total_hits !== 16'd6) begin n_err++; $display("[TB] FAIL b2b_total got=%0d exp=6", total_hits); end
  endtask

  task automatic test_en_drop();
    logic [8:0] partial;
    partial = 9'b0_0010_0010;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bit_en = 1'b1;
      det    = partial[i];
      tick();
    end
    en = 1'b0;
    det = 1'b1;
    tick();
    bit_en = 1'b0;
    det = 1'b0;
    n_cmp++; if (total_hits !== 16'd8) begin n_err++; $display("[TB] FAIL endrop_total got=%0d exp=8", total_hits); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("[TB] FAIL endrop_valid got=%0b exp=0", res_valid); end
    en = 1'b1;
    tick();
    send_window(16'h0021, 1'b0, 1'b1);
    n_cmp++; if (res_count !== 5'd2) begin n_err++; $display("[TB] FAIL reenter_count got=%0d exp=2", res_count); end
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("[TB] FAIL reenter_valid got=%0b exp=1", res_valid); end
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("[TB] FAIL reenter_alarm got=%0b exp=0", alarm); end
    n_cmp++; if (total_hits !== 16'd10) begin n_err++; $display("[TB] FAIL reenter_total got=%0d exp=10", total_hits); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      bit_en = 1'b1;
      det    = 1'b1;
      tick();
    end
    bit_en = 1'b0;
    det = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("[TB] FAIL async_valid got=%0b exp=0", res_valid); end
    n_cmp++; if (res_count !== '0) begin n_err++; $display("[TB] FAIL async_count got=%0d exp=0", res_count); end
    n_cmp++; if (total_hits !== 16'd0) begin n_err++; $display("[TB] FAIL async_total got=%0d exp=0", total_hits); end
    n_cmp++; if ({alarm, overrun} !== 2'b00) begin n_err++; $display("[TB] FAIL async_flags got=%b exp=00", {alarm, overrun}); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    en = 1'b1;
    tick();
    send_window(16'hFFFF, 1'b0, 1'b0);
    n_cmp++; if (res_count !== 5'd16) begin n_err++; $display("[TB] FAIL sat_full_count got=%0d exp=16", res_count); end
    n_cmp++; if (s_total_hits !== 4'd15) begin n_err++; $display("[TB] FAIL sat_small_mid got=%0d exp=15", s_total_hits); end
    send_window(16'h000F, 1'b0, 1'b0);
    n_cmp++; if (total_hits !== 16'd20) begin n_err++; $display("[TB] FAIL sat_wide_total got=%0d exp=20", total_hits); end
    n_cmp++; if (s_total_hits !== 4'd15) begin n_err++; $display("[TB] FAIL sat_small_total got=%0d exp=15", s_total_hits); end
    n_cmp++; if (res_count !== 5'd16) begin n_err++; $display("[TB] FAIL sat_held_count got=%0d exp=16", res_count); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("[TB] FAIL sat_overrun got=%0b exp=1", overrun); end
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_last_bit_hit();
    test_overrun();
    test_back_to_back();
    test_en_drop();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
